// File: rtl/pfb_count_pkg.sv
// Shared definitions for the channelizer item/cycle counters: default widths, the
// delay-line entry layout and the tag sequencing rule.
package pfb_count_pkg;

    localparam int unsigned DATA_W_DEF = 36;
    localparam int unsigned CNT_W_DEF  = 11;
    localparam int unsigned TAG_MAX_W  = 32;

    typedef logic [TAG_MAX_W-1:0] tag_wide_t;

    // Default-width line entry; parametrised blocks declare the same layout locally.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [CNT_W_DEF-1:0]  tag;
        logic                  last;
    } line_entry_t;

    // Callers truncate the result to their counter width, which gives the 2^W wrap.
    function automatic tag_wide_t next_tag(input tag_wide_t prev, input tag_wide_t period,
                                           input logic first, input logic rst);
        if (first || rst) begin
            return '0;
        end
        if ((period != '0) && (prev == period - tag_wide_t'(1))) begin
            return '0;
        end
        return prev + tag_wide_t'(1);
    endfunction

    function automatic logic is_last(input tag_wide_t tag, input tag_wide_t period);
        return (period != '0) && (tag == period - tag_wide_t'(1));
    endfunction

endpackage

// File: rtl/count_items_axis_if.sv
// Stream-side bundle of count_items_axis: input handshake, tag controls and
// output handshake with tag/last sidebands.
interface count_items_axis_if
    import pfb_count_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              reset_cnt_i;
    logic [CNT_W-1:0]  period_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  count_o;
    logic              last_o;

    modport slave (
        input  valid_i, data_i, reset_cnt_i, period_i, ready_i,
        output ready_o, valid_o, data_o, count_o, last_o
    );

    modport master (
        output valid_i, data_i, reset_cnt_i, period_i, ready_i,
        input  ready_o, valid_o, data_o, count_o, last_o
    );
endinterface

// File: rtl/count_tag_gen.sv
// Running tag generator: produces the tag and last flag for the sample being
// accepted this cycle and remembers it as the previous tag.
module count_tag_gen
    import pfb_count_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             accept,
    input  logic             reset_cnt,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] tag,
    output logic             last
);
    logic             first_q;
    logic [CNT_W-1:0] prev_tag_q;

    always_comb begin
        tag  = CNT_W'(next_tag(tag_wide_t'(prev_tag_q), tag_wide_t'(period), first_q, reset_cnt));
        last = is_last(tag_wide_t'(tag), tag_wide_t'(period));
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            first_q    <= 1'b1;
            prev_tag_q <= '0;
        end else if (accept) begin
            first_q    <= 1'b0;
            prev_tag_q <= tag;
        end
    end
endmodule

// File: rtl/count_items_axis.sv
// Item counter with ready/valid: tags each accepted sample, delays it by DELAY
// accepts and presents it from a registered output stage.
module count_items_axis
    import pfb_count_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DELAY  = 2
) (
    input logic               clk,
    input logic               sync_reset,
    count_items_axis_if.slave bus
);
    localparam int unsigned FillW = $clog2(DELAY + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  tag;
        logic              last;
    } entry_t;

    entry_t           line_q [DELAY];
    entry_t           new_entry;
    entry_t           out_q;
    logic [FillW-1:0] fill_q;
    logic             valid_q;
    logic             ready;
    logic             accept;
    logic             line_full;
    logic [CNT_W-1:0] tag;
    logic             last;

    assign ready     = bus.ready_i | ~valid_q;
    assign accept    = bus.valid_i & ready;
    assign line_full = (fill_q == FillW'(DELAY));

    count_tag_gen #(
        .CNT_W (CNT_W)
    ) u_tag_gen (
        .clk        (clk),
        .sync_reset (sync_reset),
        .accept     (accept),
        .reset_cnt  (bus.reset_cnt_i),
        .period     (bus.period_i),
        .tag        (tag),
        .last       (last)
    );

    always_comb begin
        new_entry      = '0;
        new_entry.data = bus.data_i;
        new_entry.tag  = tag;
        new_entry.last = last;
    end

    // Line only moves on accept; samples stay parked until pushed by later input.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                line_q[i] <= '0;
            end
            fill_q <= '0;
        end else if (accept) begin
            line_q[0] <= new_entry;
            for (int i = 1; i < int'(DELAY); i++) begin
                line_q[i] <= line_q[i-1];
            end
            if (!line_full) begin
                fill_q <= fill_q + FillW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (accept) begin
            valid_q <= line_full;
            if (line_full) begin
                out_q <= line_q[DELAY-1];
            end
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = out_q.data;
    assign bus.count_o = out_q.tag;
    assign bus.last_o  = out_q.last;
endmodule

// File: tb/tb_count_items_axis.sv
// Scoreboard bench for count_items_axis: two configurations driven by shared random
// stimulus, each checked against a sample-queue reference model.
module tb_count_items_axis;
    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic        vld = 1'b0;
    logic        rc = 1'b0;
    logic        rdy = 1'b1;
    logic [35:0] din = '0;
    logic [10:0] per = '0;

    int checks = 0;
    int errors = 0;

    count_items_axis_if #(.DATA_W(36), .CNT_W(11)) bus0 ();
    count_items_axis_if #(.DATA_W(16), .CNT_W(4))  bus1 ();

    assign bus0.valid_i     = vld;
    assign bus0.data_i      = din;
    assign bus0.reset_cnt_i = rc;
    assign bus0.period_i    = per;
    assign bus0.ready_i     = rdy;
    assign bus1.valid_i     = vld;
    assign bus1.data_i      = din[15:0];
    assign bus1.reset_cnt_i = rc;
    assign bus1.period_i    = per[3:0];
    assign bus1.ready_i     = rdy;

    count_items_axis #(.DATA_W(36), .CNT_W(11), .DELAY(2)) dut0 (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus0)
    );

    count_items_axis #(.DATA_W(16), .CNT_W(4), .DELAY(3)) dut1 (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] data;
        int          tag;
        bit          last;
    } exp_t;

    exp_t hist [2][$];
    exp_t expq [2][$];
    bit   mvalid [2] = '{1'b0, 1'b0};
    bit   mfirst [2] = '{1'b1, 1'b1};
    int   mprev  [2] = '{0, 0};
    int   xfers  [2] = '{0, 0};
    int   dly    [2] = '{2, 3};
    int   cw     [2] = '{11, 4};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void get_out(input int k, output logic v, output logic r,
                                    output logic [35:0] d, output logic [31:0] c,
                                    output logic l);
        if (k == 0) begin
            v = bus0.valid_o; r = bus0.ready_o; d = bus0.data_o;
            c = 32'(bus0.count_o); l = bus0.last_o;
        end else begin
            v = bus1.valid_o; r = bus1.ready_o; d = {20'b0, bus1.data_o};
            c = 32'(bus1.count_o); l = bus1.last_o;
        end
    endfunction

    // Reference model: tags are positions in a period-long cycle; outputs are the
    // accepted samples minus the newest DELAY ones still parked in the line.
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int   p;
            int   t;
            int   m;
            bit   acc;
            exp_t e;
            m = 1 << cw[k];
            if (sync_reset) begin
                hist[k].delete();
                expq[k].delete();
                mvalid[k] = 1'b0;
                mfirst[k] = 1'b1;
                mprev[k]  = 0;
            end else begin
                p   = int'(per) % m;
                acc = vld && (rdy || !mvalid[k]);
                if (acc) begin
                    if (mfirst[k] || rc) t = 0;
                    else if (p != 0 && mprev[k] == p - 1) t = 0;
                    else t = (mprev[k] + 1) % m;
                    mfirst[k] = 1'b0;
                    mprev[k]  = t;
                    e.data = (k == 0) ? din : {20'b0, din[15:0]};
                    e.tag  = t;
                    e.last = (p != 0) && (t == p - 1);
                    hist[k].push_back(e);
                    if (hist[k].size() > dly[k]) begin
                        expq[k].push_back(hist[k].pop_front());
                        mvalid[k] = 1'b1;
                    end else begin
                        mvalid[k] = 1'b0;
                    end
                end else if (rdy) begin
                    mvalid[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: compares presented output with the scoreboard head every cycle,
    // pops it when the transfer actually happens.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic        v;
            logic        r;
            logic [35:0] d;
            logic [31:0] c;
            logic        l;
            exp_t        e;
            get_out(k, v, r, d, c, l);
            if (sync_reset) begin
                chk($sformatf("rst_valid[%0d]", k), 64'(v), 64'(0));
                chk($sformatf("rst_data[%0d]", k), 64'(d), 64'(0));
                chk($sformatf("rst_count[%0d]", k), 64'(c), 64'(0));
                chk($sformatf("rst_last[%0d]", k), 64'(l), 64'(0));
            end else begin
                chk($sformatf("valid[%0d]", k), 64'(v), 64'(mvalid[k]));
                chk($sformatf("ready[%0d]", k), 64'(r), 64'(rdy | !mvalid[k]));
                if (mvalid[k]) begin
                    if (expq[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty[%0d] actual=output required=none", k);
                    end else begin
                        e = expq[k][0];
                        chk($sformatf("data[%0d]", k), 64'(d), 64'(e.data));
                        chk($sformatf("count[%0d]", k), 64'(c), 64'(e.tag));
                        chk($sformatf("last[%0d]", k), 64'(l), 64'(e.last));
                        if (rdy) begin
                            void'(expq[k].pop_front());
                            xfers[k]++;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input bit v, input bit r, input bit rd);
        vld = v;
        rc  = r;
        rdy = rd;
        din = {4'($urandom), 32'($urandom)};
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] pick_period();
        case ($urandom_range(0, 7))
            0: return 11'd0;
            1: return 11'd1;
            2: return 11'd2;
            3: return 11'd4;
            4: return 11'd5;
            5: return 11'd7;
            6: return 11'd16;
            default: return 11'($urandom_range(0, 40));
        endcase
    endfunction

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 39) == 0) per = pick_period();
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 sync_reset = 1'b0;

        // Free-run priming, then a period of 4
        per = 11'd0;
        repeat (5) cyc(1'b1, 1'b0, 1'b1);
        per = 11'd4;
        repeat (10) cyc(1'b1, 1'b0, 1'b1);

        // reset_cnt without a valid sample is ignored, then applied mid-period
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);

        // Downstream stall with output valid
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1);

        per = 11'd1;
        repeat (6) cyc(1'b1, 1'b0, 1'b1);

        // Long free run wraps the narrow counter several times
        per = 11'd0;
        repeat (40) cyc(1'b1, 1'b0, 1'b1);

        // Period shrunk below the current tag: no early wrap
        per = 11'd3;
        repeat (20) cyc(1'b1, 1'b0, 1'b1);

        rand_run(600);

        // Reset mid-stream, then priming again
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 sync_reset = 1'b0;
        per = 11'd5;
        repeat (8) cyc(1'b1, 1'b0, 1'b1);

        rand_run(300);

        vld = 1'b0;
        rc  = 1'b0;
        rdy = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sb_drained[%0d]", k), 64'(expq[k].size()), 64'(0));
            chk($sformatf("xfers_seen[%0d]", k), 64'(xfers[k] > 50), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
